osd_him_mux: RTL
================

# osd_him_mux

Multi-channel host interface module. It bridges one GLIP 16-bit word stream to NUM_CH independent DII flit ports, with a channel-tagged length header on every packet. Ingress packets are validated, then routed to or dropped from per-channel full-packet buffers. Egress packets from all channels are round-robin arbitrated onto the single GLIP output. It sits between the GLIP host link and NUM_CH debug-ring attachment points in the OSD subsystem, and is the multi-channel successor of the single-channel HIM.

## Interface
Parameters:
- NUM_CH, 2: number of DII channels, 1..16.
- MAX_PKT_LEN, 12: max flits per packet, excluding the header, 1..31.
- BUF_SIZE, MAX_PKT_LEN: per-channel buffer depth, in flits, for each direction.

Ports:
- clk  in  1  clock.
- rst  in  1  reset (rst): synchronous, active-high.
- glip_in  glip_channel.slave  16  host-to-chip words.
- glip_out  glip_channel.master  16  chip-to-host words.
- dii_out[NUM_CH]  out  dii_flit  per-channel ingress flits.
- dii_out_ready[NUM_CH]  in  1  per-channel sink ready.
- dii_in[NUM_CH]  in  dii_flit  per-channel egress flits.
- dii_in_ready[NUM_CH]  out  1  per-channel egress buffer ready.
- err_count  out  16  count of dropped ingress packets; saturates at 0xFFFF.

## Operation
- Header word format: bits [4:0] = size N (flit count); bits [15:12] = channel ID; bits [11:5] = 0 on egress and ignored on ingress.
- Each direction uses one dii_buffer per channel with FULLPACKET=1. Buffer contents are lost on rst.

Ingress FSM, states HDR / FWD / DROP:
- HDR:
  - glip_in.ready = 1.
  - On accept, latch ch and rem = N-1.
  - If N=0: stay in HDR, no flits, not counted as an error.
  - Else if ch >= NUM_CH or N > MAX_PKT_LEN: go to DROP and increment err_count.
  - Else: go to FWD.
- FWD:
  - glip_in.ready = the ingress buffer's flit_in_ready for ch.
  - Flit to the buffer: data = word, valid = glip_in.valid, last = (rem==0).
  - On each accept, rem decrements.
  - The accept with rem==0 returns to HDR.
- DROP:
  - glip_in.ready = 1. Consume N words with no DII output.
  - The final word returns to HDR.
- A word is accepted when glip_in.valid & glip_in.ready. rem is 5 bits wide; its decrement never wraps because the exit condition is rem==0.

Egress FSM, states IDLE / HDR / BODY:
- IDLE:
  - Request vector = flit_out.valid of each egress buffer; with FULLPACKET=1 a request means a complete packet is present.
  - If any request is set, grant the first requester at or after rr_ptr (cyclic), register the grant, and go to HDR.
- HDR:
  - glip_out.valid = 1; glip_out.data = {grant[3:0], 7'b0, packet_size[4:0]}, where packet_size comes from the granted buffer.
  - On glip_out.ready, go to BODY.
- BODY:
  - glip_out.data = flit.data; glip_out.valid = flit.valid; granted buffer flit_out_ready = glip_out.ready.
  - Other buffers' flit_out_ready = 0 in all states.
  - On accept of a flit with last=1: rr_ptr = grant+1 mod NUM_CH, go to IDLE.
- rr_ptr resets to 0.

## Timing
- Reset values (asserted in the cycle after rst is sampled high): ingress FSM in HDR, egress FSM in IDLE, glip_out.valid=0, all dii_out[i].valid=0, all dii_in_ready[i] per empty buffer (1), err_count=0, rr_ptr=0. glip_in.ready is 0 while rst=1.
- rst mid-packet: both FSMs abort immediately and buffers flush. Partial ingress packets are discarded, never delivered. A partial egress packet is truncated on GLIP; host resync is outside scope.
- Ingress latency: header accepted at cycle 0, flits 1..N at cycles ≥1. The first dii_out[ch].valid appears only after the last flit is written (FULLPACKET), at the buffer's write-to-read latency.
- Egress: 1 IDLE cycle for arbitration, then header, then N flits back-to-back if glip_out.ready=1. Minimum cost is N+2 cycles per packet.
- Simultaneous requests: rr order only, with no starvation. Each channel is served within NUM_CH packets.
- A full ingress buffer on the target channel backpressures glip_in in FWD only. DROP and HDR never stall.
- err_count increments at most once per header and holds at 0xFFFF.

## Test plan
- NUM_CH=2, header 0x1003 + words A,B,C -> dii_out[1] delivers A,B,C with last on C only; dii_out[0] stays idle; err_count=0.
- Header 0x3002 (ch 3 >= NUM_CH) + 2 words, then header 0x0001 + D -> the 2 words are discarded, err_count=1, dii_out[0] delivers D with last.
- Header size 20 (>12) -> 20 words consumed with glip_in.ready held at 1, err_count increments once, the next header is parsed correctly. Header 0x0000 -> no output, no error.
- Channels 0 and 1 each load a 2-flit packet simultaneously -> glip_out emits 0x0002,f0a,f0b then 0x1002,f1a,f1b; the next simultaneous pair starts with channel 0 again (rr_ptr wrapped).
- glip_out.ready toggled 1/0 every cycle during egress -> no word duplicated or lost, header precedes each body, total 3 words per 2-flit packet.
- rst asserted during ingress FWD after 1 of 3 flits -> no dii_out valid afterwards; a new complete packet following reset is delivered intact.

Source files
------------

// File: rtl/osd_him_mux.sv
// Multi-channel host interface: one GLIP word stream <-> NUM_CH DII ports.
// Ingress packets are validated and routed, egress packets are round-robin merged.

module osd_him_mux_buf #(
    parameter int SIZE = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_data,
    input  logic        i_last,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [15:0] o_data,
    output logic        o_last,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [4:0]  o_size
);
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [AW:0] DEPTH = (AW+1)'(SIZE);
    localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);

    logic [16:0]   r_mem [SIZE];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic [AW:0]   r_npkt;
    logic          w_wr;
    logic          w_rd;
    logic [AW:0]   w_j;

    assign o_ready = (r_cnt != DEPTH);
    // Full-packet mode: only expose the head once a whole packet is stored
    assign o_valid = (r_npkt != '0);
    assign {o_last, o_data} = r_mem[r_rd];
    assign w_wr = i_valid & o_ready;
    assign w_rd = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr] <= {i_last, i_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_npkt <= '0;
        end else begin
            if (w_wr) begin
                r_wr <= (r_wr == LAST_IDX) ? '0 : r_wr + 1'b1;
            end
            if (w_rd) begin
                r_rd <= (r_rd == LAST_IDX) ? '0 : r_rd + 1'b1;
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            unique case ({w_wr & i_last, w_rd & o_last})
                2'b10:   r_npkt <= r_npkt + 1'b1;
                2'b01:   r_npkt <= r_npkt - 1'b1;
                default: r_npkt <= r_npkt;
            endcase
        end
    end

    // Size of the head packet: distance to the first stored last flit
    always_comb begin
        o_size = '0;
        w_j    = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            w_j = (AW+1)'(r_rd) + (AW+1)'(i);
            if (w_j >= DEPTH) begin
                w_j = w_j - DEPTH;
            end
            if (((AW+1)'(i) < r_cnt) && r_mem[w_j[AW-1:0]][16]) begin
                o_size = 5'(i + 1);
            end
        end
    end
endmodule

module osd_him_mux #(
    parameter int NUM_CH      = 2,
    parameter int MAX_PKT_LEN = 12,
    parameter int BUF_SIZE    = MAX_PKT_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              i_glip_in_data,
    input  logic                     i_glip_in_valid,
    output logic                     o_glip_in_ready,
    output logic [15:0]              o_glip_out_data,
    output logic                     o_glip_out_valid,
    input  logic                     i_glip_out_ready,
    output logic [NUM_CH-1:0][15:0]  o_dii_out_data,
    output logic [NUM_CH-1:0]        o_dii_out_last,
    output logic [NUM_CH-1:0]        o_dii_out_valid,
    input  logic [NUM_CH-1:0]        i_dii_out_ready,
    input  logic [NUM_CH-1:0][15:0]  i_dii_in_data,
    input  logic [NUM_CH-1:0]        i_dii_in_last,
    input  logic [NUM_CH-1:0]        i_dii_in_valid,
    output logic [NUM_CH-1:0]        o_dii_in_ready,
    output logic [15:0]              o_err_count
);
    typedef enum logic [1:0] {I_HDR, I_FWD, I_DROP} in_state_t;
    typedef enum logic [1:0] {E_IDLE, E_HDR, E_BODY} eg_state_t;

    in_state_t r_in_state;
    in_state_t w_in_nxt;
    eg_state_t r_eg_state;
    eg_state_t w_eg_nxt;

    logic [3:0]  r_ch;
    logic [4:0]  r_rem;
    logic [15:0] r_err;
    logic [3:0]  r_grant;
    logic [3:0]  r_rr;

    logic [NUM_CH-1:0]       w_ib_in_valid;
    logic [NUM_CH-1:0]       w_ib_in_ready;
    logic [NUM_CH-1:0]       w_eb_out_valid;
    logic [NUM_CH-1:0]       w_eb_out_last;
    logic [NUM_CH-1:0]       w_eb_out_ready;
    logic [NUM_CH-1:0][15:0] w_eb_out_data;
    logic [NUM_CH-1:0][4:0]  w_eb_size;

    logic [4:0]  w_hdr_n;
    logic [3:0]  w_hdr_ch;
    logic        w_hdr_bad;
    logic        w_gi_ready;
    logic        w_gi_acc;
    logic        w_sel_in_ready;
    logic        w_sel_valid;
    logic        w_sel_last;
    logic [15:0] w_sel_data;
    logic [4:0]  w_sel_size;
    logic        w_found;
    logic [3:0]  w_pick;
    int          w_idx;

    assign w_hdr_n   = i_glip_in_data[4:0];
    assign w_hdr_ch  = i_glip_in_data[15:12];
    assign w_hdr_bad = (int'(w_hdr_ch) >= NUM_CH) ||
                       (int'(w_hdr_n) > MAX_PKT_LEN);
    assign o_glip_in_ready = w_gi_ready & ~rst;
    assign w_gi_acc    = i_glip_in_valid & o_glip_in_ready;
    assign o_err_count = r_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        osd_him_mux_buf #(.SIZE(BUF_SIZE)) u_ib (
            .clk     (clk),
            .rst     (rst),
            .i_data  (i_glip_in_data),
            .i_last  (r_rem == 5'd0),
            .i_valid (w_ib_in_valid[g]),
            .o_ready (w_ib_in_ready[g]),
            .o_data  (o_dii_out_data[g]),
            .o_last  (o_dii_out_last[g]),
            .o_valid (o_dii_out_valid[g]),
            .i_ready (i_dii_out_ready[g]),
            .o_size  ()
        );
        osd_him_mux_buf #(.SIZE(BUF_SIZE)) u_eb (
            .clk     (clk),
            .rst     (rst),
            .i_data  (i_dii_in_data[g]),
            .i_last  (i_dii_in_last[g]),
            .i_valid (i_dii_in_valid[g]),
            .o_ready (o_dii_in_ready[g]),
            .o_data  (w_eb_out_data[g]),
            .o_last  (w_eb_out_last[g]),
            .o_valid (w_eb_out_valid[g]),
            .i_ready (w_eb_out_ready[g]),
            .o_size  (w_eb_size[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state <= I_HDR;
            r_eg_state <= E_IDLE;
        end else begin
            r_in_state <= w_in_nxt;
            r_eg_state <= w_eg_nxt;
        end
    end

    always_comb begin
        w_in_nxt       = r_in_state;
        w_gi_ready     = 1'b0;
        w_ib_in_valid  = '0;
        w_sel_in_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch == 4'(i)) begin
                w_sel_in_ready = w_ib_in_ready[i];
            end
        end
        unique case (r_in_state)
            I_HDR: begin
                w_gi_ready = 1'b1;
                if (i_glip_in_valid && w_hdr_n != 5'd0) begin
                    w_in_nxt = w_hdr_bad ? I_DROP : I_FWD;
                end
            end
            I_FWD: begin
                w_gi_ready = w_sel_in_ready;
                for (int i = 0; i < NUM_CH; i++) begin
                    w_ib_in_valid[i] = (r_ch == 4'(i)) && i_glip_in_valid;
                end
                if (i_glip_in_valid && w_sel_in_ready && r_rem == 5'd0) begin
                    w_in_nxt = I_HDR;
                end
            end
            I_DROP: begin
                w_gi_ready = 1'b1;
                if (i_glip_in_valid && r_rem == 5'd0) begin
                    w_in_nxt = I_HDR;
                end
            end
            default: w_in_nxt = I_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch  <= '0;
            r_rem <= '0;
            r_err <= '0;
        end else if (w_gi_acc) begin
            if (r_in_state == I_HDR) begin
                r_ch  <= w_hdr_ch;
                r_rem <= w_hdr_n - 5'd1;
                if (w_hdr_n != 5'd0 && w_hdr_bad && r_err != 16'hFFFF) begin
                    r_err <= r_err + 16'd1;
                end
            end else if (r_rem != 5'd0) begin
                r_rem <= r_rem - 5'd1;
            end
        end
    end

    // Cyclic search for the first complete packet at or after r_rr
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            for (int j = 0; j < NUM_CH; j++) begin
                if (!w_found && j == w_idx && w_eb_out_valid[j]) begin
                    w_found = 1'b1;
                    w_pick  = 4'(j);
                end
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_size  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_grant == 4'(i)) begin
                w_sel_valid = w_eb_out_valid[i];
                w_sel_last  = w_eb_out_last[i];
                w_sel_data  = w_eb_out_data[i];
                w_sel_size  = w_eb_size[i];
            end
        end
    end

    always_comb begin
        w_eg_nxt         = r_eg_state;
        o_glip_out_valid = 1'b0;
        o_glip_out_data  = '0;
        w_eb_out_ready   = '0;
        unique case (r_eg_state)
            E_IDLE: begin
                if (w_found) begin
                    w_eg_nxt = E_HDR;
                end
            end
            E_HDR: begin
                o_glip_out_valid = 1'b1;
                o_glip_out_data  = {r_grant, 7'b0, w_sel_size};
                if (i_glip_out_ready) begin
                    w_eg_nxt = E_BODY;
                end
            end
            E_BODY: begin
                o_glip_out_valid = w_sel_valid;
                o_glip_out_data  = w_sel_data;
                for (int i = 0; i < NUM_CH; i++) begin
                    w_eb_out_ready[i] = (r_grant == 4'(i)) && i_glip_out_ready;
                end
                if (w_sel_valid && w_sel_last && i_glip_out_ready) begin
                    w_eg_nxt = E_IDLE;
                end
            end
            default: w_eg_nxt = E_IDLE;
        endcase
        if (rst) begin
            o_glip_out_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_rr    <= '0;
        end else begin
            if (r_eg_state == E_IDLE && w_found) begin
                r_grant <= w_pick;
            end
            if (r_eg_state == E_BODY && w_sel_valid &&
                w_sel_last && i_glip_out_ready) begin
                r_rr <= (int'(r_grant) == NUM_CH - 1) ? 4'd0 : r_grant + 4'd1;
            end
        end
    end
endmodule
